// File: rtl/prng_pkg.sv
// Shared types and constants for the PRNG arbiter slice.
package prng_pkg;

  typedef enum logic [1:0] {
    ARB     = 2'd0,
    SHIFT   = 2'd1,
    DELIVER = 2'd2
  } state_t;

  // Default feedback masks and seeds for common LFSR widths.
  localparam logic [3:0]  TAPS4  = 4'h9;
  localparam logic [3:0]  SEED4  = 4'hF;
  localparam logic [7:0]  TAPS8  = 8'hB8;
  localparam logic [7:0]  SEED8  = 8'hFF;
  localparam logic [15:0] TAPS16 = 16'hD008;
  localparam logic [15:0] SEED16 = 16'hFFFF;

  // First set request bit at or after ptr, wrapping modulo n (n <= 8).
  function automatic logic [2:0] rr_pick(input logic [7:0] req,
                                         input logic [2:0] ptr,
                                         input int unsigned n);
    logic [2:0]  pick;
    logic        found;
    int unsigned idx;
    pick  = ptr;
    found = 1'b0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (!found && i < n) begin
        idx = (ptr + i) % n;
        if (req[idx]) begin
          pick  = 3'(idx);
          found = 1'b1;
        end
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/prng_arbiter_if.sv
// Requester-side bus of the PRNG arbiter.
// Optional statistics outputs appear when PRNG_STATS_EN is defined.
interface prng_arbiter_if #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned WORD_W  = 8,
  parameter int unsigned LFSR_W  = 16
);
  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] ack;
  logic [WORD_W-1:0]  rdata;
  logic               seed_load;
  logic [LFSR_W-1:0]  seed_data;
  logic               busy;
`ifdef PRNG_STATS_EN
  logic [15:0]        word_count;
  logic [7:0]         drop_count;

  modport master (output req, seed_load, seed_data,
                  input  ack, rdata, busy, word_count, drop_count);
  modport slave  (input  req, seed_load, seed_data,
                  output ack, rdata, busy, word_count, drop_count);
`else
  modport master (output req, seed_load, seed_data,
                  input  ack, rdata, busy);
  modport slave  (input  req, seed_load, seed_data,
                  output ack, rdata, busy);
`endif
endinterface

// File: rtl/lfsr_core.sv
// Fibonacci LFSR with load priority and zero-seed substitution.
module lfsr_core
  import prng_pkg::*;
#(
  parameter int unsigned       LFSR_W = 16,
  parameter logic [LFSR_W-1:0] TAPS   = TAPS16,
  parameter logic [LFSR_W-1:0] SEED   = SEED16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              step,
  input  logic              load,
  input  logic [LFSR_W-1:0] load_val,
  output logic [LFSR_W-1:0] state,
  output logic              fb
);
  logic [LFSR_W-1:0] lfsr;

  assign fb    = ^(lfsr & TAPS);
  assign state = lfsr;

  // Load beats step; a zero seed would lock the register, so SEED replaces it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    lfsr <= SEED;
    else if (load) lfsr <= (load_val == '0) ? SEED : load_val;
    else if (step) lfsr <= {lfsr[LFSR_W-2:0], fb};
  end
endmodule

// File: rtl/prng_arbiter.sv
// Round-robin arbiter sharing one LFSR; each grant receives a WORD_W-bit word.
// Optional word/drop counters when PRNG_STATS_EN is defined.
module prng_arbiter
  import prng_pkg::*;
#(
  parameter int unsigned       NUM_REQ = 4,
  parameter int unsigned       WORD_W  = 8,
  parameter int unsigned       LFSR_W  = 16,
  parameter logic [LFSR_W-1:0] TAPS    = TAPS16,
  parameter logic [LFSR_W-1:0] SEED    = SEED16
) (
  input logic           CLK,
  input logic           BTN_N,
  prng_arbiter_if.slave bus
);
  localparam int unsigned CNT_W    = (WORD_W > 2) ? $clog2(WORD_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WORD_W - 1);
  localparam logic [2:0] LAST_REQ = 3'(NUM_REQ - 1);

  state_t             state, state_n;
  logic [2:0]         ptr, owner;
  logic [CNT_W-1:0]   cnt;
  logic [WORD_W-1:0]  data_sr;
  logic [7:0]         req8;
  logic [NUM_REQ-1:0] ack_vec;
  logic               step, done, drop, fb;
  logic [LFSR_W-1:0]  lfsr_q;

  lfsr_core #(.LFSR_W(LFSR_W), .TAPS(TAPS), .SEED(SEED)) u_lfsr (
    .clk      (CLK),
    .rst_n    (BTN_N),
    .step     (step),
    .load     (bus.seed_load),
    .load_val (bus.seed_data),
    .state    (lfsr_q),
    .fb       (fb)
  );

  assign req8 = 8'(bus.req);

  // FSM state register.
  always_ff @(posedge CLK or negedge BTN_N) begin
    if (!BTN_N) state <= ARB;
    else        state <= state_n;
  end

  // Next state and per-cycle controls; a seed load aborts any word in flight.
  always_comb begin
    state_n = state;
    step    = 1'b0;
    done    = 1'b0;
    drop    = 1'b0;
    ack_vec = '0;
    case (state)
      ARB: if (|req8) state_n = SHIFT;
      SHIFT: begin
        if (bus.seed_load) begin
          state_n = ARB;
          drop    = 1'b1;
        end else begin
          step = 1'b1;
          if (cnt == CNT_LAST) state_n = DELIVER;
        end
      end
      DELIVER: begin
        state_n = ARB;
        if (bus.seed_load) begin
          drop = 1'b1;
        end else begin
          done = 1'b1;
          if (req8[owner]) begin
            for (int unsigned i = 0; i < NUM_REQ; i++)
              if (owner == 3'(i)) ack_vec[i] = 1'b1;
          end else begin
            drop = 1'b1;
          end
        end
      end
      default: state_n = ARB;
    endcase
  end

  // Grant capture, word assembly and pointer advance.
  always_ff @(posedge CLK or negedge BTN_N) begin
    if (!BTN_N) begin
      ptr     <= '0;
      owner   <= '0;
      cnt     <= '0;
      data_sr <= '0;
    end else begin
      if (state == ARB && |req8) begin
        owner <= rr_pick(req8, ptr, NUM_REQ);
        cnt   <= '0;
      end
      if (step) begin
        data_sr <= {data_sr[WORD_W-2:0], fb};
        cnt     <= cnt + 1'b1;
      end
      if (done) ptr <= (owner == LAST_REQ) ? 3'd0 : owner + 3'd1;
    end
  end

  assign bus.ack   = ack_vec;
  assign bus.rdata = (|ack_vec) ? data_sr : '0;
  assign bus.busy  = (state != ARB);

  // The LFSR must never lock up at zero.
  assert property (@(posedge CLK) disable iff (!BTN_N) lfsr_q != '0);

`ifdef PRNG_STATS_EN
  // Saturating delivered/dropped word counters, cleared only by reset.
  always_ff @(posedge CLK or negedge BTN_N) begin
    if (!BTN_N) begin
      bus.word_count <= '0;
      bus.drop_count <= '0;
    end else begin
      if (|ack_vec && bus.word_count != 16'hFFFF) bus.word_count <= bus.word_count + 16'd1;
      if (drop && bus.drop_count != 8'hFF)        bus.drop_count <= bus.drop_count + 8'd1;
    end
  end
`endif
endmodule

// File: tb/tb_prng_arbiter.sv
// Scoreboard bench for prng_arbiter in the 4-bit LFSR configuration.
module tb_prng_arbiter;
  import prng_pkg::*;

  localparam int unsigned NR = 4;
  localparam int unsigned W  = 4;
  localparam int unsigned LW = 4;
  localparam logic [3:0]  TP = 4'b1001;
  localparam logic [3:0]  SD = 4'hF;

  logic CLK = 1'b0;
  logic BTN_N = 1'b0;
  always #5 CLK = ~CLK;

  prng_arbiter_if #(.NUM_REQ(NR), .WORD_W(W), .LFSR_W(LW)) bus ();

  prng_arbiter #(.NUM_REQ(NR), .WORD_W(W), .LFSR_W(LW), .TAPS(TP), .SEED(SD)) dut (
    .CLK   (CLK),
    .BTN_N (BTN_N),
    .bus   (bus)
  );

  typedef struct {
    int         cyc;
    logic [3:0] ack;
    logic [3:0] data;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  bit   exp_busy[int];
  int   cyc = 0;
  bit   mon_en = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  // Reference model state: LFSR value, round-robin pointer, counters.
  int   m_lfsr;
  int   m_ptr;
  int   m_words = 0;
  int   m_drops = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Output monitor: pops the scoreboard whenever an ack is due.
  always @(negedge CLK) begin
    if (mon_en) begin
      if (q.size() > 0 && q[0].cyc == cyc) begin
        mon_e = q.pop_front();
        check("ack", int'(bus.ack), int'(mon_e.ack));
        check("rdata", int'(bus.rdata), int'(mon_e.data));
      end else begin
        check("idle_ack", int'(bus.ack), 0);
      end
      if (bus.ack == '0) check("rdata_zero", int'(bus.rdata), 0);
      if (exp_busy.exists(cyc)) check("busy", int'(bus.busy), int'(exp_busy[cyc]));
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
    cyc++;
  endtask

  function automatic int next_bit(input int v);
    return $countones(v & int'(TP)) % 2;
  endfunction

  task automatic model_reset();
    m_lfsr = int'(SD);
    m_ptr  = 0;
  endtask

  task automatic do_reset();
    mon_en        = 1'b0;
    BTN_N         = 1'b0;
    bus.req       = '0;
    bus.seed_load = 1'b0;
    tick();
    tick();
    BTN_N = 1'b1;
    model_reset();
    mon_en = 1'b1;
  endtask

  // Seed load while idle in arbitration.
  task automatic seed_idle(input logic [3:0] sv);
    bus.req       = '0;
    bus.seed_load = 1'b1;
    bus.seed_data = sv;
    exp_busy[cyc] = 1'b0;
    m_lfsr = (sv == 4'h0) ? int'(SD) : int'(sv);
    tick();
    bus.seed_load = 1'b0;
  endtask

  // One arbitration frame. action: 0 deliver, 1 owner drops req at offset s,
  // 2 seed load at offset s (offsets 1..W are SHIFT, W+1 is DELIVER).
  task automatic run_frame(input logic [3:0] r, input int action, input int s,
                           input logic [3:0] sv, input int fix_owner, input int fix_word);
    int c0;
    int owner;
    int word;
    int fb;
    int n;
    int exp_own;
    exp_t e;
    logic [3:0] rr;
    c0            = cyc;
    bus.req       = r;
    bus.seed_load = 1'b0;
    exp_busy[c0]  = 1'b0;
    if (r == 4'h0) begin
      tick();
      return;
    end
    owner = -1;
    for (int unsigned i = 0; i < NR; i++) begin
      int idx;
      idx = (m_ptr + int'(i)) % NR;
      if (owner < 0 && r[idx]) owner = idx;
    end
    word = 0;
    for (int unsigned k = 0; k < W; k++) begin
      fb     = next_bit(m_lfsr);
      m_lfsr = (m_lfsr * 2 + fb) % 16;
      word   = word * 2 + fb;
    end
    n = (action == 2) ? s : int'(W) + 1;
    for (int k = 1; k <= n; k++) exp_busy[c0 + k] = 1'b1;
    if (action == 0) begin
      exp_own = (fix_owner >= 0) ? fix_owner : owner;
      e.cyc   = c0 + int'(W) + 1;
      e.ack   = 4'(1 << exp_own);
      e.data  = (fix_word >= 0) ? 4'(fix_word) : 4'(word);
      q.push_back(e);
      m_words++;
      m_ptr = (owner + 1) % NR;
    end else if (action == 1) begin
      m_drops++;
      m_ptr = (owner + 1) % NR;
    end else begin
      m_drops++;
      m_lfsr = (sv == 4'h0) ? int'(SD) : int'(sv);
    end
    tick();
    rr = r;
    for (int k = 1; k <= n; k++) begin
      bus.seed_load = 1'b0;
      if (action == 1 && k == s) begin
        rr[owner] = 1'b0;
        bus.req   = rr;
      end
      if (action == 2 && k == s) begin
        bus.seed_load = 1'b1;
        bus.seed_data = sv;
      end
      tick();
    end
    bus.seed_load = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int a;
    logic [3:0] r;
    logic [3:0] sv;
    bus.req       = '0;
    bus.seed_load = 1'b0;
    bus.seed_data = '0;
    BTN_N         = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    check("reset_ack", int'(bus.ack), 0);
    check("reset_rdata", int'(bus.rdata), 0);
    check("reset_busy", int'(bus.busy), 0);
    BTN_N = 1'b1;
    cyc   = 0;
    model_reset();
    mon_en = 1'b1;

    // Single requester: first two words from the reset seed.
    run_frame(4'b0001, 0, 0, 4'h0, 0, 4'h5);
    run_frame(4'b0001, 0, 0, 4'h0, 0, 4'h9);

    // All requesters: rotating grants, one every W+2 cycles.
    do_reset();
    run_frame(4'b1111, 0, 0, 4'h0, 0, -1);
    run_frame(4'b1111, 0, 0, 4'h0, 1, -1);
    run_frame(4'b1111, 0, 0, 4'h0, 2, -1);
    run_frame(4'b1111, 0, 0, 4'h0, 3, -1);
    run_frame(4'b1111, 0, 0, 4'h0, 0, -1);

    // Requester 2 drops mid-word; requester 3 is next.
    run_frame(4'b1100, 1, 2, 4'h0, -1, -1);
    run_frame(4'b1100, 0, 0, 4'h0, 3, -1);
`ifdef PRNG_STATS_EN
    check("drop_count_one", int'(bus.drop_count), 1);
    check("word_count_mid", int'(bus.word_count), 6);
`endif

    // Seed load aborts requester 1's word; it is re-granted.
    run_frame(4'b0010, 2, 2, 4'h5, -1, -1);
    run_frame(4'b0010, 0, 0, 4'h0, 1, 4'h9);

    // Zero seed is replaced by the reset seed.
    seed_idle(4'h0);
    run_frame(4'b0001, 0, 0, 4'h0, 0, 4'h5);

    // Asynchronous reset in the middle of a word.
    bus.req = 4'b0001;
    exp_busy[cyc] = 1'b0;
    tick();
    exp_busy[cyc] = 1'b1;
    tick();
    #2;
    BTN_N = 1'b0;
    #1;
    mon_en = 1'b0;
    check("async_rst_ack", int'(bus.ack), 0);
    check("async_rst_busy", int'(bus.busy), 0);
    check("async_rst_rdata", int'(bus.rdata), 0);
    bus.req = '0;
    tick();
    tick();
    BTN_N = 1'b1;
    model_reset();
    m_words = 0;
    m_drops = 0;
    mon_en = 1'b1;
    run_frame(4'b0001, 0, 0, 4'h0, 0, 4'h5);

    // Randomized traffic against the model.
    for (int unsigned f = 0; f < 200; f++) begin
      r  = 4'($urandom_range(0, 15));
      a  = int'($urandom_range(0, 11));
      sv = ($urandom_range(0, 4) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
      if (a == 11)     seed_idle(sv);
      else if (a >= 9) run_frame(r, 1, int'($urandom_range(1, W + 1)), 4'h0, -1, -1);
      else if (a == 8) run_frame(r, 2, int'($urandom_range(1, W + 1)), sv, -1, -1);
      else             run_frame(r, 0, 0, 4'h0, -1, -1);
    end

    bus.req = '0;
    repeat (3) tick();
    check("scoreboard_drained", q.size(), 0);
`ifdef PRNG_STATS_EN
    check("word_count", int'(bus.word_count), m_words);
    check("drop_count", int'(bus.drop_count), m_drops);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/prng_arbiter.md
Name: prng_arbiter

Overview:
Shares one Fibonacci LFSR between NUM_REQ requesters.
- Round-robin grant per request; the granted requester receives one WORD_W-bit word assembled serially from the LFSR output.
- Provides seed loading and deterministic stepping: the LFSR advances only while a word is being built.
- Sits between the top-level LFSR datapath and consumers such as the P1A9 bit stream, LED effects and test-pattern generators.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
WORD_W, 8, bits per delivered word (2..LFSR_W)
LFSR_W, 16, LFSR register width
TAPS, 16'hD008, feedback mask; fb = XOR-reduce(lfsr & TAPS)
SEED, 16'hFFFF (all ones, LFSR_W bits), reset value and substitute for a zero seed

Ports:
CLK  in  1  system clock
BTN_N  in  1  reset; one clock; reset is asynchronous and active-low (BTN_N low resets all state immediately)
req  in  NUM_REQ  level request per requester; held until ack
ack  out  NUM_REQ  one-hot, one-cycle pulse; word valid for that requester
rdata  out  WORD_W  delivered word; valid only while ack != 0
seed_load  in  1  single-cycle pulse, load seed_data into LFSR
seed_data  in  LFSR_W  seed value
busy  out  1  high in SHIFT and DELIVER

Behaviour:
- Reset values: lfsr=SEED; state=ARB; ptr=0; cnt=0; data_sr=0; ack=0; rdata=0; busy=0.
- LFSR step: lfsr <= {lfsr[LFSR_W-2:0], fb}. The new bit fb is the output bit.
- ARB:
  - If any req bit is set, pick the first set bit searching from ptr upward with wrap.
  - Register owner, cnt=0, then go to SHIFT.
  - Otherwise stay in ARB; the LFSR holds.
- SHIFT:
  - Each cycle: step the LFSR, data_sr <= {data_sr[WORD_W-2:0], fb}, cnt++.
  - After WORD_W steps, go to DELIVER.
- DELIVER:
  - If req[owner] is still high: ack[owner]=1 and rdata=data_sr for exactly that cycle.
  - If req[owner] has dropped: no ack and the word is discarded.
  - In either case: ptr <= (owner+1) mod NUM_REQ, then go to ARB.
- Latency: req sampled in ARB at cycle 0 -> ack in cycle WORD_W+1. Throughput is one word per WORD_W+2 cycles.
- Fairness: a requester holding req continuously waits at most NUM_REQ-1 words.
- req dropping during SHIFT: the word is still completed (the LFSR has advanced) and discarded in DELIVER.
- seed_load:
  - Accepted in any state and takes priority over stepping.
  - lfsr <= (seed_data==0) ? SEED : seed_data.
  - In SHIFT or DELIVER: the current word is aborted, no ack, ptr is unchanged, and the next state is ARB.
- Zero-lock: the LFSR can never hold 0 via reset or seed. TAPS must be set so that 0 is unreachable.
- Reset mid-word: immediate return to the reset values; no ack is issued.
- rdata returns to 0 whenever ack is 0 (no stale data visible).

Optional Feature:
PRNG_STATS_EN
- Defined:
  - Adds output word_count [15:0], incremented on every delivered ack and saturating at 16'hFFFF.
  - Adds output drop_count [7:0], incremented on each discarded or aborted word and saturating at 8'hFF.
  - Both counters are cleared by reset only.
- Undefined: both ports and both counters are absent; behaviour is otherwise identical.

Decomposition:
- Package prng_pkg holds:
  - state enum: ARB=2'd0, SHIFT=2'd1, DELIVER=2'd2;
  - default TAPS/SEED constants for widths 4, 8 and 16;
  - a function for the round-robin next-index search.
- Sub-module lfsr_core (parameters LFSR_W, TAPS, SEED):
  - inputs step, load, load_val; outputs state and fb;
  - contains the zero-seed substitution.
- The arbiter FSM, ptr, cnt and data_sr live in prng_arbiter.

Test Plan:
(All with LFSR_W=4, TAPS=4'b1001, SEED=4'hF, WORD_W=4, NUM_REQ=4 unless noted.)
1. Reset release, hold req=4'b0001 -> first ack=4'b0001 with rdata=4'h5 in cycle 5 after req sampled; second ack rdata=4'h9; ack is one cycle wide, rdata is 0 between acks.
2. req=4'b1111 held -> ack order 0001, 0010, 0100, 1000, 0001; spacing 6 cycles.
3. seed_load with seed_data=0 -> LFSR=4'hF; the next word equals 4'h5.
4. seed_load=1 with seed_data=4'h5 during SHIFT cycle 2 for requester 1 -> no ack, ptr unchanged; requester 1 is re-granted and gets rdata=4'h9.
5. Requester 2 drops req during SHIFT -> no ack; requester 3 (also requesting) is granted next; with PRNG_STATS_EN, drop_count=1 and word_count unchanged.
6. BTN_N asserted mid-SHIFT, asynchronously between clock edges -> ack, busy and rdata go to 0 immediately; after release, the sequence restarts at word 4'h5.
